// File: rtl/score_bcd_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) driving
// registered seven-segment outputs with leading-zero blanking and overflow dashes.
module score_bcd_display #(
  parameter int SCORE_W        = 8,
  parameter int DIGITS         = 2,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  score_valid,
  input  logic                  freeze,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  localparam logic [6:0] SEG_DASH  = (SEG_ACTIVE_LOW != 0) ? 7'h3F : 7'h40;
  localparam logic [6:0] SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [63:0] max_score();
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < DIGITS; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_SCORE = max_score();

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? c : ~c;
  endfunction

  function automatic logic [SEG_W-1:0] reset_segs();
    logic [SEG_W-1:0] r;
    for (int k = 0; k < DIGITS; k++)
      r[7*k +: 7] = (k == 0 || BLANK_LZ == 0) ? seg_code(4'd0) : SEG_BLANK;
    return r;
  endfunction

  localparam logic [SEG_W-1:0] RESET_SEGS = reset_segs();

  // Walk from the most significant digit down; zeros stay blank until the first non-zero digit.
  function automatic logic [SEG_W-1:0] decode_segs(input logic [BCD_W-1:0] v, input logic ovf);
    logic [SEG_W-1:0] r;
    logic             lead;
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (v[4*k +: 4] != 4'd0) lead = 1'b0;
      if (ovf)
        r[7*k +: 7] = SEG_DASH;
      else if (lead && k != 0 && BLANK_LZ != 0)
        r[7*k +: 7] = SEG_BLANK;
      else
        r[7*k +: 7] = seg_code(v[4*k +: 4]);
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] v, input logic bit_in);
    logic [BCD_W-1:0] a;
    a = v;
    for (int k = 0; k < DIGITS; k++)
      if (a[4*k +: 4] >= 4'd5) a[4*k +: 4] = a[4*k +: 4] + 4'd3;
    return {a[BCD_W-2:0], bit_in};
  endfunction

  state_t             state;
  logic [SCORE_W-1:0] shreg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_cap;
  logic               pend_valid;
  logic [SCORE_W-1:0] pend_score;

  logic               req;
  logic               start;
  logic [SCORE_W-1:0] start_score;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    req         = score_valid && !freeze;
    start       = 1'b0;
    start_score = score;
    case (state)
      IDLE:   start = req;
      COMMIT: begin
        // A request landing in the commit cycle is newer than the pending one.
        start       = req || (pend_valid && !freeze);
        start_score = req ? score : pend_score;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments; later assignments in this block
  // deliberately override earlier ones (e.g. a new start supersedes the IDLE return).
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_cap    <= 1'b0;
      pend_valid <= 1'b0;
      pend_score <= '0;
      done       <= 1'b0;
      bcd        <= '0;
      segments   <= RESET_SEGS;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;

      if (freeze) begin
        pend_valid <= 1'b0;
      end else if (score_valid && state != IDLE) begin
        pend_valid <= 1'b1;
        pend_score <= score;
      end

      case (state)
        CONV: begin
          scratch <= dabble_step(scratch, shreg[SCORE_W-1]);
          shreg   <= shreg << 1;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd      <= ovf_cap ? {DIGITS{4'h9}} : scratch;
          segments <= decode_segs(scratch, ovf_cap);
          overflow <= ovf_cap;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: ;
      endcase

      if (start) begin
        shreg      <= start_score;
        scratch    <= '0;
        cnt        <= CNT_W'(SCORE_W);
        ovf_cap    <= (64'(start_score) > MAX_SCORE);
        pend_valid <= 1'b0;
        state      <= CONV;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display: stimulus queues expected commits,
// a negedge monitor pops and compares on every done pulse.
module tb_score_bcd_display;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  score = '0;
  logic        score_valid = 1'b0;
  logic        freeze = 1'b0;

  logic        busy, done, overflow;
  logic [7:0]  bcd;
  logic [13:0] segments;
  logic        busy_nb, done_nb, overflow_nb;
  logic [7:0]  bcd_nb;
  logic [13:0] segments_nb;

  score_bcd_display dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .score(score), .score_valid(score_valid),
    .freeze(freeze), .busy(busy), .done(done), .bcd(bcd), .segments(segments),
    .overflow(overflow)
  );

  score_bcd_display #(.BLANK_LZ(0)) dut_nb (
    .clk_25mhz(clk_25mhz), .reset(reset), .score(score), .score_valid(score_valid),
    .freeze(freeze), .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .segments(segments_nb),
    .overflow(overflow_nb)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic [13:0] seg_nb;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_result(input logic [7:0] b, input logic [6:0] d1, input logic [6:0] d0,
                                        input logic [6:0] n1, input logic [6:0] n0, input logic o);
    exp_t e;
    e.bcd    = b;
    e.seg    = {d1, d0};
    e.seg_nb = {n1, n0};
    e.ovf    = o;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk_25mhz) begin
    if (reset && (done || done_nb)) begin
      check("done_match", done_nb, done);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done bcd=%h with no queued result at %0t", bcd, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("bcd", bcd, mon_e.bcd);
        check("segments", segments, mon_e.seg);
        check("segments_noblank", segments_nb, mon_e.seg_nb);
        check("overflow", overflow, mon_e.ovf);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  // Caller sits at a negedge; the request is sampled by the next rising edge.
  task automatic send(input logic [7:0] s);
    score       = s;
    score_valid = 1'b1;
    @(negedge clk_25mhz);
    score_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk_25mhz);
      n++;
    end
    check(name, n, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_segments", segments, {7'h7F, 7'h40});
    check("rst_segments_noblank", segments_nb, {7'h40, 7'h40});
    reset = 1'b1;

    expect_result(8'h12, 7'h79, 7'h24, 7'h79, 7'h24, 1'b0);
    send(8'd12);
    check("busy_in_conv", busy, 1'b1);
    measure_latency("latency_12");
    wait_idle();

    expect_result(8'h07, 7'h7F, 7'h78, 7'h40, 7'h78, 1'b0);
    send(8'd7);   wait_idle();
    expect_result(8'h99, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    send(8'd200); wait_idle();
    tick(3);
    check("overflow_hold", overflow, 1'b1);
    expect_result(8'h05, 7'h7F, 7'h12, 7'h40, 7'h12, 1'b0);
    send(8'd5);   wait_idle();
    expect_result(8'h00, 7'h7F, 7'h40, 7'h40, 7'h40, 1'b0);
    send(8'd0);   wait_idle();
    expect_result(8'h99, 7'h10, 7'h10, 7'h10, 7'h10, 1'b0);
    send(8'd99);  wait_idle();
    expect_result(8'h99, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    send(8'd100); wait_idle();
    expect_result(8'h99, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
    send(8'd255); wait_idle();

    // Last pending request wins; 34 must never commit.
    expect_result(8'h12, 7'h79, 7'h24, 7'h79, 7'h24, 1'b0);
    send(8'd12);
    tick(2);
    send(8'd34);
    tick(1);
    expect_result(8'h56, 7'h12, 7'h02, 7'h12, 7'h02, 1'b0);
    send(8'd56);
    wait_idle();

    // Request sampled exactly on the commit edge chains straight into a new conversion.
    expect_result(8'h21, 7'h24, 7'h79, 7'h24, 7'h79, 1'b0);
    send(8'd21);
    tick(8);
    expect_result(8'h33, 7'h30, 7'h30, 7'h30, 7'h30, 1'b0);
    send(8'd33);
    check("busy_after_commit_req", busy, 1'b1);
    wait_idle();

    // Freeze lets 45 finish, drops the queued 67, and ignores new requests.
    expect_result(8'h45, 7'h19, 7'h12, 7'h19, 7'h12, 1'b0);
    send(8'd45);
    tick(2);
    send(8'd67);
    tick(1);
    freeze = 1'b1;
    wait_idle();
    score       = 8'd88;
    score_valid = 1'b1;
    tick(3);
    check("frozen_ignore_busy", busy, 1'b0);
    score_valid = 1'b0;
    tick(12);
    check("frozen_hold_bcd", bcd, 8'h45);
    freeze = 1'b0;

    // Reset mid-conversion discards both the active and the pending request.
    send(8'd99);
    send(8'd11);
    tick(2);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_bcd", bcd, 8'h00);
    check("midrst_segments", segments, {7'h7F, 7'h40});
    check("midrst_segments_noblank", segments_nb, {7'h40, 7'h40});
    tick(2);
    reset = 1'b1;
    tick(15);
    check("post_rst_idle", busy, 1'b0);

    expect_result(8'h42, 7'h19, 7'h24, 7'h19, 7'h24, 1'b0);
    send(8'd42);
    measure_latency("latency_42");
    wait_idle();
    tick(2);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
